// File: rtl/imem_uart_loader.sv
// UART program loader: receives an 8N1 framed byte stream (0xA5, COUNT, data words)
// and writes big-endian 32-bit words into instruction memory, holding the CPU until done.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RxD,
  output logic                  IM_WrEn,
  output logic [ADDR_WIDTH-1:0] IM_WrAddr,
  output logic [31:0]           IM_WrData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       HEADER    = 8'hA5;
  localparam logic [16:0]      CAPACITY  = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_CNT_HI,
    LD_CNT_LO,
    LD_DATA,
    LD_WRITE,
    LD_DONE
  } ldState_t;

  rxState_t r_rxState, w_rxNext;
  ldState_t r_ldState, w_ldNext;

  logic                  r_rxMeta, r_rxSync, r_rxPrev;
  logic [CNT_W-1:0]      r_clkCnt;
  logic [2:0]            r_bitIdx;
  logic [7:0]            r_shift;
  logic [7:0]            r_byte;
  logic                  r_byteValid, r_frameErr;

  logic [7:0]            r_countHi;
  logic [15:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [16:0]           r_written;
  logic [1:0]            r_byteIdx;
  logic [23:0]           r_assembly;
  logic                  r_wrEn;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [31:0]           r_wrData;
  logic                  r_cpuHold, r_done, r_error;

  logic                  w_fallEdge, w_halfTick, w_bitTick;
  logic                  w_header, w_countZero, w_countBig, w_lastWord;
  logic [15:0]           w_count;

  assign w_fallEdge  = r_rxPrev & ~r_rxSync;
  assign w_halfTick  = (r_clkCnt == HALF_LAST);
  assign w_bitTick   = (r_clkCnt == BIT_LAST);

  assign w_header    = r_byteValid && (r_byte == HEADER);
  assign w_count     = {r_countHi, r_byte};
  assign w_countZero = (w_count == 16'd0);
  assign w_countBig  = ({1'b0, w_count} > CAPACITY);
  assign w_lastWord  = ((r_written + 17'd1) == {1'b0, r_count});

  // RxD idles high, so the synchronizer and edge history reset to 1 to avoid a false start.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= RxD;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_rxState <= RX_IDLE;
    else      r_rxState <= w_rxNext;
  end

  always_comb begin
    w_rxNext = r_rxState;
    unique case (r_rxState)
      RX_IDLE:  if (w_fallEdge) w_rxNext = RX_START;
      RX_START: if (w_halfTick) w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bitTick && (r_bitIdx == 3'd7)) w_rxNext = RX_STOP;
      RX_STOP:  if (w_bitTick) w_rxNext = RX_IDLE;
      default:  w_rxNext = RX_IDLE;
    endcase
  end

  // Bit timing counts from the mid-start sample, so every later sample lands mid-bit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_clkCnt    <= '0;
      r_bitIdx    <= 3'd0;
      r_shift     <= 8'd0;
      r_byte      <= 8'd0;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
      unique case (r_rxState)
        RX_IDLE: begin
          r_clkCnt <= '0;
          r_bitIdx <= 3'd0;
        end
        RX_START: begin
          r_clkCnt <= w_halfTick ? '0 : r_clkCnt + 1'b1;
        end
        RX_DATA: begin
          if (w_bitTick) begin
            r_clkCnt <= '0;
            r_shift  <= {r_rxSync, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_bitTick) begin
            r_clkCnt <= '0;
            if (r_rxSync) begin
              r_byteValid <= 1'b1;
              r_byte      <= r_shift;
            end else begin
              r_frameErr  <= 1'b1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        default: r_clkCnt <= '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_ldState <= LD_IDLE;
    else      r_ldState <= w_ldNext;
  end

  // A framing error aborts any in-progress load; DONE is the only state it leaves alone.
  always_comb begin
    w_ldNext = r_ldState;
    unique case (r_ldState)
      LD_IDLE, LD_DONE: begin
        if (w_header) w_ldNext = LD_CNT_HI;
      end
      LD_CNT_HI: begin
        if (r_frameErr)       w_ldNext = LD_IDLE;
        else if (r_byteValid) w_ldNext = LD_CNT_LO;
      end
      LD_CNT_LO: begin
        if (r_frameErr) begin
          w_ldNext = LD_IDLE;
        end else if (r_byteValid) begin
          if (w_countZero)     w_ldNext = LD_DONE;
          else if (w_countBig) w_ldNext = LD_IDLE;
          else                 w_ldNext = LD_DATA;
        end
      end
      LD_DATA: begin
        if (r_frameErr)                               w_ldNext = LD_IDLE;
        else if (r_byteValid && (r_byteIdx == 2'd3))  w_ldNext = LD_WRITE;
      end
      LD_WRITE: begin
        w_ldNext = w_lastWord ? LD_DONE : LD_DATA;
      end
      default: w_ldNext = LD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_countHi  <= 8'd0;
      r_count    <= 16'd0;
      r_addr     <= '0;
      r_written  <= 17'd0;
      r_byteIdx  <= 2'd0;
      r_assembly <= 24'd0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= 32'd0;
      r_cpuHold  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wrEn <= 1'b0;
      if (r_frameErr) r_error <= 1'b1;
      unique case (r_ldState)
        LD_IDLE, LD_DONE: begin
          if (w_header) begin
            r_error   <= 1'b0;
            r_cpuHold <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        LD_CNT_HI: begin
          if (r_byteValid) r_countHi <= r_byte;
        end
        LD_CNT_LO: begin
          if (r_byteValid) begin
            r_count   <= w_count;
            r_addr    <= '0;
            r_written <= 17'd0;
            r_byteIdx <= 2'd0;
            if (w_countZero) begin
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else if (w_countBig) begin
              r_error   <= 1'b1;
            end
          end
        end
        LD_DATA: begin
          if (r_byteValid) begin
            r_assembly <= {r_assembly[15:0], r_byte};
            r_byteIdx  <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              r_wrEn   <= 1'b1;
              r_wrAddr <= r_addr;
              r_wrData <= {r_assembly, r_byte};
            end
          end
        end
        LD_WRITE: begin
          r_addr    <= r_addr + 1'b1;
          r_written <= r_written + 17'd1;
          if (w_lastWord) begin
            r_done    <= 1'b1;
            r_cpuHold <= 1'b0;
          end
        end
        default: r_wrEn <= 1'b0;
      endcase
    end
  end

  assign IM_WrEn   = r_wrEn;
  assign IM_WrAddr = r_wrAddr;
  assign IM_WrData = r_wrData;
  assign CpuHold   = r_cpuHold;
  assign Done      = r_done;
  assign Error     = r_error;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serialises 8N1 frames and checks writes and status flags.
module tb_imem_uart_loader;

  localparam int BIT = 4;
  localparam int AW  = 4;

  logic          Clk;
  logic          Rst;
  logic          RxD;
  logic          IM_WrEn;
  logic [AW-1:0] IM_WrAddr;
  logic [31:0]   IM_WrData;
  logic          CpuHold;
  logic          Done;
  logic          Error;

  int compared;
  int mismatched;

  logic [AW-1:0] wrAddrQ[$];
  logic [31:0]   wrDataQ[$];
  logic [7:0]    txQ[$];

  imem_uart_loader #(
    .CLKS_PER_BIT(BIT),
    .ADDR_WIDTH  (AW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RxD      (RxD),
    .IM_WrEn  (IM_WrEn),
    .IM_WrAddr(IM_WrAddr),
    .IM_WrData(IM_WrData),
    .CpuHold  (CpuHold),
    .Done     (Done),
    .Error    (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Every cycle with the strobe high is logged, so a stretched pulse shows up as an extra write.
  always @(negedge Clk) begin
    if (IM_WrEn === 1'b1) begin
      wrAddrQ.push_back(IM_WrAddr);
      wrDataQ.push_back(IM_WrData);
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(posedge Clk); #1 RxD = 1'b0;
    repeat (BIT) @(posedge Clk);
    for (int i = 0; i < 8; i++) begin
      #1 RxD = b[i];
      repeat (BIT) @(posedge Clk);
    end
    #1 RxD = stopBit;
    repeat (BIT) @(posedge Clk);
    #1 RxD = 1'b1;
    repeat (BIT) @(posedge Clk);
  endtask

  task automatic sendQueue();
    foreach (txQ[i]) sendByte(txQ[i], 1'b1);
    @(negedge Clk);
  endtask

  task automatic doReset();
    #1 Rst = 1'b0;
    RxD = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    repeat (3) @(posedge Clk);
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic checkStatus(input string tag, input logic expHold, input logic expDone,
                             input logic expErr, input int expWrites);
    compared++;
    if (CpuHold !== expHold) begin
      mismatched++;
      $display("[TB] FAIL %s_hold: got %b expected %b", tag, CpuHold, expHold);
    end
    compared++;
    if (Done !== expDone) begin
      mismatched++;
      $display("[TB] FAIL %s_done: got %b expected %b", tag, Done, expDone);
    end
    compared++;
    if (Error !== expErr) begin
      mismatched++;
      $display("[TB] FAIL %s_error: got %b expected %b", tag, Error, expErr);
    end
    compared++;
    if (wrAddrQ.size() != expWrites) begin
      mismatched++;
      $display("[TB] FAIL %s_writes: got %0d expected %0d", tag, wrAddrQ.size(), expWrites);
    end
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [AW-1:0] expAddr,
                            input logic [31:0] expData);
    logic [AW-1:0] gotAddr;
    logic [31:0]   gotData;
    gotAddr = (idx < wrAddrQ.size()) ? wrAddrQ[idx] : 'x;
    gotData = (idx < wrDataQ.size()) ? wrDataQ[idx] : 'x;
    compared++;
    if ((gotAddr !== expAddr) || (gotData !== expData)) begin
      mismatched++;
      $display("[TB] FAIL %s_write%0d: got (%0d, %h) expected (%0d, %h)",
               tag, idx, gotAddr, gotData, expAddr, expData);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    RxD = 1'b1;
    repeat (2) @(negedge Clk);
    compared++;
    if ((IM_WrEn !== 1'b0) || (IM_WrAddr !== 4'd0) || (IM_WrData !== 32'd0)) begin
      mismatched++;
      $display("[TB] FAIL reset_wrport: got en=%b addr=%0d data=%h expected 0/0/0",
               IM_WrEn, IM_WrAddr, IM_WrData);
    end
    checkStatus("reset", 1'b1, 1'b0, 1'b0, 0);
    #1 Rst = 1'b1;
    repeat (3) @(posedge Clk);
  endtask

  task automatic test_normal_load();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    sendQueue();
    checkStatus("normal_mid", 1'b1, 1'b0, 1'b0, 1);
    checkWrite("normal", 0, 4'd0, 32'h12345678);
    txQ = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sendQueue();
    checkStatus("normal_end", 1'b0, 1'b1, 1'b0, 2);
    checkWrite("normal", 1, 4'd1, 32'hDEADBEEF);
  endtask

  task automatic test_garbage_header();
    doReset();
    txQ = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    sendQueue();
    checkStatus("garbage", 1'b0, 1'b1, 1'b0, 1);
    checkWrite("garbage", 0, 4'd0, 32'hCAFEBABE);
  endtask

  task automatic test_zero_oversize();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h00};
    sendQueue();
    checkStatus("zero", 1'b0, 1'b1, 1'b0, 0);
    sendByte(8'h5A, 1'b0);
    @(negedge Clk);
    checkStatus("done_frameerr", 1'b0, 1'b1, 1'b1, 0);
    doReset();
    txQ = {8'hA5, 8'h00, 8'h11};
    sendQueue();
    checkStatus("oversize", 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_framing_error();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    sendQueue();
    sendByte(8'h33, 1'b0);
    @(negedge Clk);
    checkStatus("frameerr", 1'b1, 1'b0, 1'b1, 0);
    txQ = {8'hA5};
    sendQueue();
    checkStatus("frameerr_hdr", 1'b1, 1'b0, 1'b0, 0);
    txQ = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    sendQueue();
    checkStatus("frameerr_reload", 1'b0, 1'b1, 1'b0, 1);
    checkWrite("frameerr", 0, 4'd0, 32'h01020304);
  endtask

  task automatic test_glitch();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h01, 8'hAA};
    sendQueue();
    @(posedge Clk); #1 RxD = 1'b0;
    @(posedge Clk); #1 RxD = 1'b1;
    repeat (12) @(posedge Clk);
    txQ = {8'hBB, 8'hCC, 8'hDD};
    sendQueue();
    checkStatus("glitch", 1'b0, 1'b1, 1'b0, 1);
    checkWrite("glitch", 0, 4'd0, 32'hAABBCCDD);
  endtask

  task automatic test_reset_midframe();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'h0F, 8'h55, 8'hAA};
    sendQueue();
    txQ = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    sendQueue();
    checkStatus("pre_rst", 1'b1, 1'b0, 1'b0, 2);
    wrAddrQ.delete();
    wrDataQ.delete();
    @(posedge Clk); #1 RxD = 1'b0;
    repeat (6) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    compared++;
    if ((IM_WrEn !== 1'b0) || (IM_WrAddr !== 4'd0) || (IM_WrData !== 32'd0)) begin
      mismatched++;
      $display("[TB] FAIL async_rst_wrport: got en=%b addr=%0d data=%h expected 0/0/0",
               IM_WrEn, IM_WrAddr, IM_WrData);
    end
    checkStatus("async_rst", 1'b1, 1'b0, 1'b0, 0);
    RxD = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Rst = 1'b1;
    repeat (3) @(posedge Clk);
    txQ = {8'h33, 8'h44, 8'h00, 8'h01};
    sendQueue();
    checkStatus("post_rst", 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_full_capacity();
    doReset();
    txQ = {8'hA5, 8'h00, 8'h10};
    for (int w = 0; w < 16; w++) begin
      txQ.push_back(8'h00);
      txQ.push_back(8'h00);
      txQ.push_back(8'h00);
      txQ.push_back(8'(w));
    end
    sendQueue();
    checkStatus("full", 1'b0, 1'b1, 1'b0, 16);
    for (int w = 0; w < 16; w++) begin
      checkWrite("full", w, 4'(w), 32'(w));
    end
    txQ = {8'hA5};
    sendQueue();
    checkStatus("full_reload", 1'b1, 1'b0, 1'b0, 16);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst        = 1'b0;
    RxD        = 1'b1;
    test_reset();
    test_normal_load();
    test_garbage_header();
    test_zero_oversize();
    test_framing_error();
    test_glitch();
    test_reset_midframe();
    test_full_capacity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Serial program loader that receives a framed byte stream on a UART RX line and writes 32-bit words into the pipelined CPU's instruction memory. It is the write side of the instruction memory, opposite the IF stage that reads it. It holds the CPU in hold (`CpuHold`) from reset until a complete program is loaded, then releases the pipeline. Clocked on the board clock `Clk`, not the divided CPU clock.

## Interface

Parameters:
- `CLKS_PER_BIT`, 868: `Clk` cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `ADDR_WIDTH`, 10: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- `Clk`, input, 1: system clock. All logic is on the rising edge.
- `Rst`, input, 1: reset, asynchronous, active-low. Asserting it low clears all state immediately.
- `RxD`, input, 1: UART serial input. Asynchronous; idles high. Format is 8N1, LSB first.
- `IM_WrEn`, output, 1: instruction-memory write strobe. Single-cycle pulse.
- `IM_WrAddr`, output, ADDR_WIDTH: word address for the write.
- `IM_WrData`, output, 32: word to write.
- `CpuHold`, output, 1: high keeps the CPU in reset/hold.
- `Done`, output, 1: a load completed successfully. Sticky.
- `Error`, output, 1: framing or length error. Sticky until the next valid header or reset.

## Operation

Receiver:
- `RxD` passes through a 2-FF synchronizer.
- A falling edge on the synchronized line starts a byte.
- At CLKS_PER_BIT/2 (integer division), the line is re-sampled:
  - If it is high, the event is a glitch; return to idle with no byte.
  - If it is low, sample 8 data bits, each CLKS_PER_BIT apart, LSB first.
- The stop bit is sampled one CLKS_PER_BIT after the last data bit.
  - Stop = 1: produce an internal `byte_valid` pulse for one cycle.
  - Stop = 0: framing error. Set `Error`, return the loader FSM to IDLE, and drop the byte.
- After a stop-bit sample, the receiver accepts a new falling edge on the next cycle.

Frame: `0xA5`, COUNT_HI, COUNT_LO, then 4×COUNT data bytes.
- Each data word is big-endian: the first byte is bits [31:24].
- Words are written to addresses 0, 1, …, COUNT−1.

Loader FSM (advances on `byte_valid`):
- IDLE:
  - `0xA5` → CNT_HI. This clears `Error`, sets `CpuHold` = 1, and clears `Done`.
  - Any other byte is ignored and the FSM stays in IDLE.
- CNT_HI: latch the byte → CNT_LO.
- CNT_LO: latch the byte to form the 16-bit COUNT.
  - COUNT = 0 → DONE.
  - COUNT > 2^ADDR_WIDTH → set `Error` → IDLE.
  - Otherwise, clear the address and byte index → DATA.
- DATA:
  - Shift each byte into a 32-bit assembly register.
  - On the 4th byte, drive `IM_WrData`/`IM_WrAddr` and pulse `IM_WrEn` → WRITE.
- WRITE (1 cycle):
  - Increment the address and the written count.
  - If the written count equals COUNT → DONE, else → DATA.
- DONE: `Done` = 1 and `CpuHold` = 0. A new `0xA5` byte restarts the load (same as IDLE).

Boundary rules:
- A framing error in any non-IDLE state aborts the load. `CpuHold` stays 1, `Done` stays 0, and memory contents already written stay written.
- A framing error while in DONE sets `Error` only. `Done` and `CpuHold` are unchanged and the FSM stays in DONE.
- COUNT = 2^ADDR_WIDTH is legal. The final address is all-ones, and the address register wraps to 0 without effect.

Reset values:
- `IM_WrEn` = 0, `IM_WrAddr` = 0, `IM_WrData` = 0.
- `CpuHold` = 1, `Done` = 0, `Error` = 0.
- FSM in IDLE, receiver idle.

## Timing

- Synchronizer latency: 2 cycles from a `RxD` edge to the internal line.
- `byte_valid` fires about 9.5×CLKS_PER_BIT cycles after the start edge, within synchronizer latency ±1 cycle.
- `IM_WrEn` asserts on the cycle after the `byte_valid` of the 4th byte of each word. It is high for exactly 1 cycle. `IM_WrAddr`/`IM_WrData` are stable during that cycle and hold until the next write.
- `CpuHold` falls and `Done` rises together:
  - on the cycle after the WRITE cycle of the last word, or
  - on the cycle after COUNT_LO when COUNT = 0.
- There is no back-pressure. The memory must accept a write every cycle. At most one write occurs per 4 bytes.
- Asserting `Rst` low mid-byte or mid-frame returns everything to reset values asynchronously. The next frame must start with a fresh header.

## Test plan

Sim parameters: CLKS_PER_BIT = 4, ADDR_WIDTH = 4.

1. Normal load: send A5 00 02 12 34 56 78 DE AD BE EF.
   - Expect two `IM_WrEn` pulses: (0, 0x12345678) and (1, 0xDEADBEEF).
   - Expect `Done` = 1 and `CpuHold` = 0 after the 2nd write.
2. Garbage before header: send 00 FF A5 00 01 CA FE BA BE.
   - The leading bytes are ignored.
   - Expect a single write (0, 0xCAFEBABE) and `Done` = 1.
3. Zero-length and oversize:
   - A5 00 00: `Done` = 1 with no writes.
   - After reset, A5 00 11 (17 > 16): `Error` = 1, `CpuHold` = 1, no writes.
4. Framing error mid-word: send A5 00 01 11 22, then a byte with stop bit 0.
   - Expect `Error` = 1, no write, and FSM back in IDLE.
   - A subsequent A5 00 01 01 02 03 04 clears `Error` and writes (0, 0x01020304).
5. Glitch and reset:
   - A 1-cycle low pulse on `RxD` produces no byte.
   - Asserting `Rst` low during byte 3 of a word returns all outputs to reset values immediately. No write occurs for the partial word.
6. Full capacity: COUNT = 16 with data words 0..15.
   - Expect the last write at address 15.
   - Expect `Done` = 1 and reload on a new header to re-assert `CpuHold`.
